mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width and meaning.
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- run  in  1  enable; sampled in IDLE and at instruction retire.
- opcode  in  7  instruction[6:0] from IR; stable from DECODE until retire.
- zero  in  1  ALU zero flag; used in BRANCH only.
- mem_ready  in  1  memory completion; qualifies the current mem_req cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write strobe; valid only with mem_req.
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR and old_pc (datapath).
- pc_write  out  1  load PC.
- pc_src  out  2  00 = PC+4, 01 = old_pc+imm.
- alu_src_a  out  2  00 = old_pc, 01 = rs1, 10 = zero.
- alu_src_b  out  2  00 = rs2, 01 = imm.
- alu_op  out  3  000 add, 001 branch-compare, 010 R-type, 011 I-type, 100 upper.
- result_src  out  2  00 = ALU, 01 = mem data, 10 = PC+4.
- reg_write  out  1  register-file write strobe.
- illegal  out  1  unsupported opcode trapped.
- state  out  4  current state encoding (debug).
- retired  out  32  retired-instruction count.

Function
REQ-002 The sequencer SHALL be a Moore FSM; outputs SHALL decode combinationally from state, plus zero in BRANCH and opcode in UPPER and MEM_ADDR; every output not listed for a state SHALL be 0.
REQ-003 State encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ALU_WB=5, MEM_ADDR=6, MEM_RD=7, MEM_WB=8, MEM_WR=9, BRANCH=10, JAL=11, UPPER=12, TRAP=15. Codes 13 and 14 SHALL go to TRAP.
REQ-004 IDLE: no outputs asserted; run=1 -> FETCH, else stay.
REQ-005 FETCH: mem_req=1, addr_sel=0.
- mem_ready=0 -> stay.
- mem_ready=1 -> ir_write=1, pc_write=1, pc_src=00 in the same cycle; next DECODE.
REQ-006 DECODE: no strobes; dispatch on opcode.
- 0110011 -> EXEC_R.
- 0010011 -> EXEC_I.
- 0000011 or 0100011 -> MEM_ADDR.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- 0110111 or 0010111 -> UPPER.
- any other -> TRAP.
REQ-007 EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=010; next ALU_WB.
REQ-008 EXEC_I: alu_src_a=01, alu_src_b=01, alu_op=011; next ALU_WB.
REQ-009 ALU_WB: reg_write=1, result_src=00; retire.
REQ-010 MEM_ADDR: alu_src_a=01, alu_src_b=01, alu_op=000; next MEM_RD if opcode=0000011, else MEM_WR.
REQ-011 MEM_RD: mem_req=1, addr_sel=1; mem_ready=1 -> MEM_WB, else stay.
REQ-012 MEM_WB: reg_write=1, result_src=01; retire.
REQ-013 MEM_WR: mem_req=1, mem_we=1, addr_sel=1; mem_ready=1 -> retire, else stay.
REQ-014 BRANCH: alu_src_a=01, alu_src_b=00, alu_op=001; if zero=1, also pc_write=1 and pc_src=01; retire.
REQ-015 JAL: reg_write=1, result_src=10, pc_write=1, pc_src=01; retire.
REQ-016 UPPER: alu_op=100, alu_src_b=01, reg_write=1, result_src=00; alu_src_a=10 for LUI (0110111), 00 for AUIPC.
REQ-017 Retire SHALL take effect on the state's final cycle: retired increments by 1 modulo 2^32 (wrap 0xFFFFFFFF -> 0); next FETCH if run=1, else IDLE.
REQ-018 mem_ready SHALL be ignored whenever mem_req=0; mem_req SHALL never deassert before mem_ready is sampled high.
REQ-019 TRAP: illegal=1, all strobes 0, retired frozen; exit only by reset.

Reset
REQ-020 On reset assertion, asynchronously: state=IDLE, retired=0, illegal=0, and all other outputs 0, including mid-handshake (mem_req drops in the same cycle).
REQ-021 After reset deasserts, the FSM SHALL remain in IDLE until run=1 is sampled.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- R-type (0110011), mem_ready=1 in first FETCH cycle -> states 1,2,3,5 then FETCH; reg_write for 1 cycle; retired=1.
- Load (0000011), mem_ready delayed 3 cycles in MEM_RD -> mem_req/addr_sel=1 held 4 cycles; MEM_WB result_src=01; retired+1.
- BEQ (1100011) with zero=1, then with zero=0 -> pc_write=1/pc_src=01 only in the taken case; both retire.
- Opcode 1111111 -> TRAP, illegal=1, retired frozen, run ignored; reset -> state=0, illegal=0.
- Reset asserted mid-MEM_WR while waiting on mem_ready -> mem_req/mem_we drop immediately, retired=0; retired preloaded to 0xFFFFFFFF wraps to 0 on retire.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle instruction sequencer for a simple RV32-style core.
// Moore control FSM that steps each instruction through fetch, decode, execute,
// memory and write-back. Control outputs decode combinationally from the current
// state; a few also depend on an input: mem_ready in FETCH, zero in BRANCH, and
// opcode in UPPER and MEM_ADDR.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   run               enable, sampled in IDLE and at instruction retire
//   opcode[6:0]       instruction opcode, stable from DECODE until retire
//   zero              ALU zero flag (BRANCH only)
//   mem_ready         memory completion for the current mem_req cycle
//   mem_req, mem_we, addr_sel              memory handshake / address select
//   ir_write, pc_write, pc_src             IR / PC load controls
//   alu_src_a, alu_src_b, alu_op           ALU operand and operation select
//   result_src, reg_write                  register-file write-back controls
//   illegal           unsupported opcode trapped
//   state[3:0]        current state (debug)
//   retired[31:0]     retired-instruction counter (wraps modulo 2^32)
module mc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        reg_write,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd2;
  localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd3;
  localparam logic [STATE_W-1:0] S_EXEC_I   = 4'd4;
  localparam logic [STATE_W-1:0] S_ALU_WB   = 4'd5;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd6;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd7;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd8;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd10;
  localparam logic [STATE_W-1:0] S_JAL      = 4'd11;
  localparam logic [STATE_W-1:0] S_UPPER    = 4'd12;
  localparam logic [STATE_W-1:0] S_TRAP     = 4'd15;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [CNT_W-1:0]   r_retired;
  logic               w_retire;

  // State and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    result_src = 2'b00;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        // IR and PC+4 load in the completing cycle of the fetch handshake
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_LUI, OP_AUIPC:  w_next = S_UPPER;
          default:           w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 3'b010;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 3'b011;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        w_next    = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        w_retire   = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        w_retire = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 3'b001;
        if (zero) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end
        w_retire = 1'b1;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 2'b01;
        w_retire   = 1'b1;
      end
      S_UPPER: begin
        alu_op    = 3'b100;
        alu_src_b = 2'b01;
        reg_write = 1'b1;
        alu_src_a = (opcode == OP_LUI) ? 2'b10 : 2'b00;
        w_retire  = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
    // Retire hands off to the next fetch, or parks in IDLE when run is low
    if (w_retire) w_next = run ? S_FETCH : S_IDLE;
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed bench for mc_sequencer. Each cycle the expected
// state, control outputs and retire count are pushed to a scoreboard queue and
// popped for comparison against the DUT once the outputs have settled.
module tb_mc_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [1:0]  result_src;
  logic        reg_write;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret;
  logic [53:0] sb_q[$];

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] J_OP  = 7'b1101111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUI   = 7'b0010111;
  localparam logic [6:0] BAD   = 7'b1111111;

  mc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .reg_write(reg_write),
    .illegal(illegal), .state(state), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control outputs for a state, from the instruction-sequencing table
  function automatic logic [17:0] model(input logic [3:0] st, input logic z,
                                        input logic [6:0] op, input logic rdy);
    logic mreq, mwe, asel, irw, pcw, rw, ill;
    logic [1:0] psrc, sa, sb, rs;
    logic [2:0] aop;
    {mreq, mwe, asel, irw, pcw, rw, ill} = 7'b0;
    {psrc, sa, sb, rs} = 8'b0;
    aop = 3'b000;
    case (st)
      4'd1:  begin mreq = 1'b1; irw = rdy; pcw = rdy; end
      4'd3:  begin sa = 2'b01; aop = 3'b010; end
      4'd4:  begin sa = 2'b01; sb = 2'b01; aop = 3'b011; end
      4'd5:  rw = 1'b1;
      4'd6:  begin sa = 2'b01; sb = 2'b01; end
      4'd7:  begin mreq = 1'b1; asel = 1'b1; end
      4'd8:  begin rw = 1'b1; rs = 2'b01; end
      4'd9:  begin mreq = 1'b1; mwe = 1'b1; asel = 1'b1; end
      4'd10: begin sa = 2'b01; aop = 3'b001; pcw = z; psrc = z ? 2'b01 : 2'b00; end
      4'd11: begin rw = 1'b1; rs = 2'b10; pcw = 1'b1; psrc = 2'b01; end
      4'd12: begin aop = 3'b100; sb = 2'b01; rw = 1'b1; sa = (op == 7'b0110111) ? 2'b10 : 2'b00; end
      4'd15: ill = 1'b1;
      default: ;
    endcase
    return {mreq, mwe, asel, irw, pcw, psrc, sa, sb, aop, rs, rw, ill};
  endfunction

  task automatic drv(input logic r, input logic [6:0] op, input logic z, input logic rdy);
    run = r; opcode = op; zero = z; mem_ready = rdy;
  endtask

  // Push expectation, let outputs settle, pop and compare
  task automatic chk(input string tag, input logic [3:0] st);
    logic [53:0] exp_v;
    logic [53:0] obs_v;
    sb_q.push_back({st, model(st, zero, opcode, mem_ready), exp_ret});
    #1;
    exp_v = sb_q.pop_front();
    obs_v = {state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, result_src, reg_write, illegal, retired};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed st=%0d ctl=%h ret=%h, expected st=%0d ctl=%h ret=%h",
             tag, obs_v[53:50], obs_v[49:32], obs_v[31:0],
             exp_v[53:50], exp_v[49:32], exp_v[31:0]);
    end
  endtask

  // One clocked cycle: check current state, then advance; ret marks a retire edge
  task automatic cyc(input string tag, input logic [3:0] st, input logic ret);
    chk(tag, st);
    @(posedge clk);
    #1;
    if (ret) exp_ret = exp_ret + 32'd1;
  endtask

  task automatic fetch_decode(input logic [6:0] op);
    drv(1'b1, op, 1'b1, 1'b1);
    cyc("fetch", 4'd1, 1'b0);
    drv(1'b1, op, 1'b1, 1'b0);
    cyc("decode", 4'd2, 1'b0);
  endtask

  initial begin
    exp_ret = 32'd0;
    reset = 1'b1;
    drv(1'b0, 7'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset", 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drv(1'b0, 7'd0, 1'b0, 1'b1);
    cyc("idle_hold0", 4'd0, 1'b0);
    cyc("idle_hold1", 4'd0, 1'b0);

    // R-type, fetch completes in its first cycle
    drv(1'b1, R_OP, 1'b0, 1'b0);
    cyc("r_idle", 4'd0, 1'b0);
    drv(1'b1, R_OP, 1'b0, 1'b1);
    cyc("r_fetch", 4'd1, 1'b0);
    drv(1'b1, R_OP, 1'b0, 1'b0);
    cyc("r_decode", 4'd2, 1'b0);
    cyc("r_exec", 4'd3, 1'b0);
    cyc("r_wb", 4'd5, 1'b1);

    // Load with mem_ready delayed three cycles in MEM_RD
    drv(1'b1, LD_OP, 1'b0, 1'b1);
    cyc("ld_fetch", 4'd1, 1'b0);
    drv(1'b1, LD_OP, 1'b0, 1'b0);
    cyc("ld_decode", 4'd2, 1'b0);
    cyc("ld_addr", 4'd6, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ld_rd_wait", 4'd7, 1'b0);
    drv(1'b1, LD_OP, 1'b0, 1'b1);
    cyc("ld_rd_done", 4'd7, 1'b0);
    drv(1'b1, LD_OP, 1'b0, 1'b0);
    cyc("ld_wb", 4'd8, 1'b1);

    // BEQ taken, then not taken with run low at retire
    fetch_decode(BR_OP);
    drv(1'b1, BR_OP, 1'b1, 1'b0);
    cyc("beq_taken", 4'd10, 1'b1);
    fetch_decode(BR_OP);
    drv(1'b0, BR_OP, 1'b0, 1'b1);
    cyc("beq_not_taken", 4'd10, 1'b1);
    drv(1'b1, BR_OP, 1'b0, 1'b0);
    cyc("beq_idle", 4'd0, 1'b0);

    // I-type, LUI, AUIPC, JAL
    fetch_decode(I_OP);
    cyc("i_exec", 4'd4, 1'b0);
    cyc("i_wb", 4'd5, 1'b1);
    fetch_decode(LUI);
    cyc("lui", 4'd12, 1'b1);
    fetch_decode(AUI);
    cyc("auipc", 4'd12, 1'b1);
    fetch_decode(J_OP);
    cyc("jal", 4'd11, 1'b1);

    // Store, reset asserted while waiting on mem_ready
    fetch_decode(ST_OP);
    cyc("st_addr", 4'd6, 1'b0);
    drv(1'b1, ST_OP, 1'b1, 1'b0);
    cyc("st_wait0", 4'd9, 1'b0);
    cyc("st_wait1", 4'd9, 1'b0);
    reset = 1'b1;
    exp_ret = 32'd0;
    chk("st_reset", 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drv(1'b0, ST_OP, 1'b0, 1'b1);
    cyc("post_reset_idle", 4'd0, 1'b0);

    // Illegal opcode traps, run ignored, retire count frozen
    drv(1'b1, BAD, 1'b0, 1'b0);
    cyc("bad_idle", 4'd0, 1'b0);
    cyc("bad_fetch_wait", 4'd1, 1'b0);
    fetch_decode(BAD);
    drv(1'b1, BAD, 1'b1, 1'b1);
    cyc("trap0", 4'd15, 1'b0);
    drv(1'b0, BAD, 1'b0, 1'b1);
    cyc("trap1", 4'd15, 1'b0);
    drv(1'b1, BAD, 1'b0, 1'b0);
    cyc("trap2", 4'd15, 1'b0);
    reset = 1'b1;
    chk("trap_reset", 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drv(1'b0, 7'd0, 1'b0, 1'b0);
    cyc("trap_exit_idle", 4'd0, 1'b0);

    // Retire counter wrap from all-ones
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    exp_ret = 32'hFFFF_FFFF;
    cyc("wrap_preload", 4'd0, 1'b0);
    drv(1'b1, J_OP, 1'b0, 1'b0);
    cyc("wrap_idle", 4'd0, 1'b0);
    fetch_decode(J_OP);
    drv(1'b0, J_OP, 1'b0, 1'b0);
    cyc("wrap_jal", 4'd11, 1'b1);
    cyc("wrap_done", 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
